// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: mult/div wait FSM
// state encodings, the ALU instruction codes that identify mul/div, and
// default sizing for the mult/div timeout and stall performance counter.
package pipeline_stall_controller_pkg;

    // Mult/div wait FSM: IDLE while the pipe flows, WAIT while multdiv owns DX.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    // ALU-class opcode and the aluop codes that select the multdiv unit.
    localparam logic [4:0] ALU_OPCODE = 5'b00000;
    localparam logic [4:0] ALUOP_MUL  = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    // Default sizing. The timeout must exceed the worst-case divide latency (33).
    localparam int MD_TIMEOUT_DEF = 40;
    localparam int CNT_W_DEF      = 32;

    // Decode helpers for whoever builds dx_is_mult / dx_is_div upstream.
    function automatic logic is_mult_insn(input logic [4:0] opcode,
                                          input logic [4:0] aluop);
        return (opcode == ALU_OPCODE) && (aluop == ALUOP_MUL);
    endfunction

    function automatic logic is_div_insn(input logic [4:0] opcode,
                                         input logic [4:0] aluop);
        return (opcode == ALU_OPCODE) && (aluop == ALUOP_DIV);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter: advances by one on each enabled cycle and sticks at
// all-ones instead of wrapping. Cleared by the asynchronous reset.
module pipeline_stall_controller_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step when enabled unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller for the 5-stage core. Turns the decode-stage
// load-use interlock, X-stage redirects and multicycle mult/div occupancy
// into PC/FD/DX write enables, bubble/flush injection and the multdiv start
// and commit handshake. The mult/div wait FSM and its timeout are the only
// stall state; all latch controls are combinational from that state plus
// the current requests, and are forced low while reset is asserted.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             interlock,
    input  logic             branch_taken,
    input  logic             dx_is_mult,
    input  logic             dx_is_div,
    input  logic             md_ready,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             md_busy,
    output logic             md_commit,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // WAIT-cycle counter; one spare bit so MD_TIMEOUT-1 always fits.
    localparam int                  MD_CNT_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [MD_CNT_W-1:0] MD_CNT_LAST = MD_CNT_W'(MD_TIMEOUT - 1);
    localparam logic [MD_CNT_W-1:0] MD_CNT_ONE  = MD_CNT_W'(1);

    md_state_e           state_q;
    md_state_e           state_d;
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;
    logic                md_timeout_q;
    logic                md_timeout_d;
    logic                md_has_insn;
    logic                md_expired;
    logic                stall_inc;

    assign md_has_insn = dx_is_mult | dx_is_div;
    assign md_expired  = (md_cnt_q == MD_CNT_LAST);

    // Next-state and latch-control decode; every output low while in reset.
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        pc_we        = 1'b0;
        fd_we        = 1'b0;
        dx_we        = 1'b0;
        fd_flush     = 1'b0;
        dx_bubble    = 1'b0;
        xm_bubble    = 1'b0;
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        md_busy      = 1'b0;
        md_commit    = 1'b0;

        if (!reset) begin
            case (state_q)
                MD_IDLE: begin
                    if (md_has_insn) begin
                        // Launch multdiv and freeze the front end; the DX
                        // insn stays put, so XM takes a nop meanwhile.
                        ctrl_mult = dx_is_mult;
                        ctrl_div  = ~dx_is_mult;
                        xm_bubble = 1'b1;
                        md_cnt_d  = '0;
                        state_d   = MD_WAIT;
                    end else if (branch_taken) begin
                        // Redirect: squash the wrong-path insns in FD and DX.
                        // DX is written so that it actually takes the nop.
                        pc_we     = 1'b1;
                        fd_we     = 1'b1;
                        dx_we     = 1'b1;
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (interlock) begin
                        // Load-use: hold PC/FD, let the load move on, and
                        // drop a nop into DX behind it.
                        dx_we     = 1'b1;
                        dx_bubble = 1'b1;
                    end else begin
                        pc_we = 1'b1;
                        fd_we = 1'b1;
                        dx_we = 1'b1;
                    end
                end

                MD_WAIT: begin
                    // Redirects and interlocks cannot be acted on while the
                    // multdiv insn blocks DX, so they are ignored here.
                    md_busy = 1'b1;
                    if (md_ready || md_expired) begin
                        // Release: the result moves into XM and the whole
                        // pipe advances; the DX insn leaves, so no re-launch.
                        md_commit = 1'b1;
                        pc_we     = 1'b1;
                        fd_we     = 1'b1;
                        dx_we     = 1'b1;
                        md_cnt_d  = '0;
                        state_d   = MD_IDLE;
                        if (!md_ready) begin
                            md_timeout_d = 1'b1;
                        end
                    end else begin
                        xm_bubble = 1'b1;
                        md_cnt_d  = md_cnt_q + MD_CNT_ONE;
                    end
                end

                default: begin
                    state_d = MD_IDLE;
                end
            endcase
        end
    end

    // FSM, WAIT counter and sticky timeout flag; reset aborts any WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= MD_IDLE;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign md_timeout = md_timeout_q;

    // Every cycle the PC is held counts as a stall cycle.
    assign stall_inc = ~pc_we;

    pipeline_stall_controller_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. A second instance with a
// 3-bit stall counter runs on the same stimulus to exercise saturation.
module tb_pipeline_stall_controller;

    logic clock;
    logic reset;
    logic interlock;
    logic branch_taken;
    logic dx_is_mult;
    logic dx_is_div;
    logic md_ready;

    logic        pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble;
    logic        ctrl_mult, ctrl_div, md_busy, md_commit, md_timeout;
    logic [31:0] stall_cycles;

    logic        s_pc_we, s_fd_we, s_dx_we, s_fd_flush, s_dx_bubble, s_xm_bubble;
    logic        s_ctrl_mult, s_ctrl_div, s_md_busy, s_md_commit, s_md_timeout;
    logic [2:0]  s_stall_cycles;

    logic [10:0] ctl;
    logic [10:0] s_ctl;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc_we fd_we dx_we | fd_flush dx_bubble xm_bubble | ctrl_mult ctrl_div | md_busy md_commit md_timeout}
    localparam logic [10:0] E_ZERO      = 11'b000_000_00_000;
    localparam logic [10:0] E_RUN       = 11'b111_000_00_000;
    localparam logic [10:0] E_INTLK     = 11'b001_010_00_000;
    localparam logic [10:0] E_BRANCH    = 11'b111_110_00_000;
    localparam logic [10:0] E_START_MUL = 11'b000_001_10_000;
    localparam logic [10:0] E_START_DIV = 11'b000_001_01_000;
    localparam logic [10:0] E_WAIT      = 11'b000_001_00_100;
    localparam logic [10:0] E_COMMIT    = 11'b111_000_00_110;
    localparam logic [10:0] E_TMO       = 11'b000_000_00_001;

    assign ctl   = {pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
                    ctrl_mult, ctrl_div, md_busy, md_commit, md_timeout};
    assign s_ctl = {s_pc_we, s_fd_we, s_dx_we, s_fd_flush, s_dx_bubble, s_xm_bubble,
                    s_ctrl_mult, s_ctrl_div, s_md_busy, s_md_commit, s_md_timeout};

    pipeline_stall_controller #(
        .MD_TIMEOUT (40),
        .CNT_W      (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .interlock    (interlock),
        .branch_taken (branch_taken),
        .dx_is_mult   (dx_is_mult),
        .dx_is_div    (dx_is_div),
        .md_ready     (md_ready),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .fd_flush     (fd_flush),
        .dx_bubble    (dx_bubble),
        .xm_bubble    (xm_bubble),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .md_busy      (md_busy),
        .md_commit    (md_commit),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    pipeline_stall_controller #(
        .MD_TIMEOUT (40),
        .CNT_W      (3)
    ) dut_small (
        .clock        (clock),
        .reset        (reset),
        .interlock    (interlock),
        .branch_taken (branch_taken),
        .dx_is_mult   (dx_is_mult),
        .dx_is_div    (dx_is_div),
        .md_ready     (md_ready),
        .pc_we        (s_pc_we),
        .fd_we        (s_fd_we),
        .dx_we        (s_dx_we),
        .fd_flush     (s_fd_flush),
        .dx_bubble    (s_dx_bubble),
        .xm_bubble    (s_xm_bubble),
        .ctrl_mult    (s_ctrl_mult),
        .ctrl_div     (s_ctrl_div),
        .md_busy      (s_md_busy),
        .md_commit    (s_md_commit),
        .md_timeout   (s_md_timeout),
        .stall_cycles (s_stall_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [10:0] exp);
        n_cmp++;
        assert (ctl === exp) else begin
            n_bad++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, exp);
        end
        n_cmp++;
        assert (s_ctl === exp) else begin
            n_bad++;
            $error("FAIL %s small_ctl observed=%b expected=%b", tag, s_ctl, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp, input logic [2:0] exp_small);
        n_cmp++;
        assert (stall_cycles === exp) else begin
            n_bad++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp);
        end
        n_cmp++;
        assert (s_stall_cycles === exp_small) else begin
            n_bad++;
            $error("FAIL %s small_stall_cycles observed=%0d expected=%0d", tag, s_stall_cycles, exp_small);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cnt;
        int mult_pulses;

        reset        = 1'b1;
        interlock    = 1'b0;
        branch_taken = 1'b0;
        dx_is_mult   = 1'b0;
        dx_is_div    = 1'b0;
        md_ready     = 1'b0;

        // Power-on reset: everything low.
        #2;
        check_ctl("por", E_ZERO);
        check_cnt("por", 32'd0, 3'd0);
        tick();
        reset = 1'b0;
        #1;
        check_ctl("idle_run", E_RUN);
        tick();

        // Divide started, reset asserted in WAIT cycle 5.
        dx_is_div = 1'b1;
        #1;
        check_ctl("rst_div_start", E_START_DIV);
        tick();
        for (int k = 1; k <= 5; k++) begin
            #1;
            check_ctl($sformatf("rst_div_wait%0d", k), E_WAIT);
            if (k < 5) tick();
        end
        check_cnt("rst_div_pre", 32'd5, 3'd5);
        reset = 1'b1;
        #1;
        check_ctl("rst_mid_wait", E_ZERO);
        check_cnt("rst_mid_wait", 32'd0, 3'd0);
        tick();
        check_ctl("rst_mid_wait_hold", E_ZERO);
        reset     = 1'b0;
        dx_is_div = 1'b0;
        md_ready  = 1'b1;
        #1;
        check_ctl("rst_release_idle_ready", E_RUN);
        check_cnt("rst_release", 32'd0, 3'd0);
        tick();
        md_ready = 1'b0;

        // One-cycle load-use interlock.
        interlock = 1'b1;
        #1;
        check_ctl("interlock", E_INTLK);
        tick();
        interlock = 1'b0;
        #1;
        check_ctl("interlock_after", E_RUN);
        check_cnt("interlock_after", 32'd1, 3'd1);
        tick();

        // Multiply, ready in the 17th WAIT cycle; hazards in WAIT ignored.
        busy_cnt    = 0;
        mult_pulses = 0;
        dx_is_mult  = 1'b1;
        #1;
        check_ctl("mul_start", E_START_MUL);
        mult_pulses += int'(ctrl_mult);
        tick();
        for (int k = 1; k <= 17; k++) begin
            md_ready     = (k == 17);
            interlock    = (k == 3);
            branch_taken = (k == 4);
            #1;
            check_ctl($sformatf("mul_wait%0d", k), (k == 17) ? E_COMMIT : E_WAIT);
            busy_cnt    += int'(md_busy);
            mult_pulses += int'(ctrl_mult);
            tick();
        end
        md_ready     = 1'b0;
        interlock    = 1'b0;
        branch_taken = 1'b0;
        dx_is_mult   = 1'b0;
        #1;
        check_ctl("mul_after", E_RUN);
        check_cnt("mul_after", 32'd18, 3'd7);
        check_int("mul_busy_cycles", busy_cnt, 17);
        check_int("mul_start_pulses", mult_pulses, 1);
        tick();

        // Branch together with interlock: branch wins.
        branch_taken = 1'b1;
        interlock    = 1'b1;
        #1;
        check_ctl("branch_vs_interlock", E_BRANCH);
        tick();
        branch_taken = 1'b0;
        interlock    = 1'b0;
        #1;
        check_ctl("branch_after", E_RUN);
        check_cnt("branch_after", 32'd18, 3'd7);
        tick();

        // Both flags set: mult wins; ready in the first WAIT cycle.
        dx_is_mult = 1'b1;
        dx_is_div  = 1'b1;
        #1;
        check_ctl("both_start", E_START_MUL);
        tick();
        md_ready = 1'b1;
        #1;
        check_ctl("both_commit", E_COMMIT);
        tick();
        md_ready   = 1'b0;
        dx_is_mult = 1'b0;
        dx_is_div  = 1'b0;
        #1;
        check_ctl("both_after", E_RUN);
        check_cnt("both_after", 32'd19, 3'd7);
        tick();

        // Divide that never completes: forced release in WAIT cycle 40.
        dx_is_div = 1'b1;
        #1;
        check_ctl("tmo_start", E_START_DIV);
        tick();
        for (int k = 1; k <= 40; k++) begin
            #1;
            check_ctl($sformatf("tmo_wait%0d", k), (k == 40) ? E_COMMIT : E_WAIT);
            tick();
        end
        dx_is_div = 1'b0;
        #1;
        check_ctl("tmo_after", E_RUN | E_TMO);
        check_cnt("tmo_after", 32'd59, 3'd7);
        tick();

        // Second divide starts normally; timeout flag stays set.
        dx_is_div = 1'b1;
        #1;
        check_ctl("div2_start", E_START_DIV | E_TMO);
        tick();
        #1;
        check_ctl("div2_wait1", E_WAIT | E_TMO);
        tick();
        md_ready = 1'b1;
        #1;
        check_ctl("div2_commit", E_COMMIT | E_TMO);
        tick();
        md_ready  = 1'b0;
        dx_is_div = 1'b0;
        #1;
        check_ctl("div2_after", E_RUN | E_TMO);
        check_cnt("div2_after", 32'd61, 3'd7);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
